// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants and types for the instruction fetch stage.
//   INST_W       - instruction word width
//   PC_INC       - byte step between sequential fetches
//   RESET_PC_DEF - default first fetch address after reset
//   fetch_entry_t - buffered {pc, inst} pair handed to the decoder
package fetch_unit_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of {pc, inst} entries.
// Ports:
//   clk, rst        - clock, async active-high reset
//   i_push/i_entry  - write an entry at the tail
//   i_pop           - drop the head entry (ignored when empty)
//   i_flush         - empty the FIFO; wins over push and pop
//   o_head          - head entry, all zeros when empty
//   o_count         - number of valid entries
//   o_empty/o_full  - occupancy flags
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  fetch_entry_t  i_entry,
  input  logic          i_pop,
  input  logic          i_flush,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign w_push  = i_push && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_head  = o_empty ? '0 : r_mem[r_rd];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset; validity is tracked by r_count. On a full
  // push+pop the write lands in the slot being read, which is fine because
  // the head is read combinationally before the edge.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Holds the PC, issues in-order word requests to imem under a credit limit,
// buffers returned words with their PCs and flushes on redirect.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   imem_req_valid/ready/addr      - fetch request channel
//   imem_rsp_valid/data            - in-order responses, no backpressure
//   redirect_valid/redirect_pc     - taken branch/jump from execute
//   inst_valid/ready, inst/inst_pc - decoder handshake
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fetch_pc, r_resp_pc;
  logic [CW-1:0] r_out;   // every request in flight, including doomed ones
  logic [CW-1:0] r_disc;  // in-flight responses still to be dropped

  fetch_entry_t  w_head, w_entry;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_used;
  logic          w_empty, w_full, w_req_fire, w_drop, w_push, w_pop;
  logic [31:0]   w_target;

  // Credit: buffered plus in-flight may never exceed the buffer size, so every
  // response is guaranteed a slot.
  assign w_used         = {1'b0, w_count} + {1'b0, r_out};
  assign imem_req_valid = !rst && !redirect_valid && (w_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_drop   = (r_disc != '0);
  assign w_push   = imem_rsp_valid && !redirect_valid && !w_drop;
  assign w_pop    = inst_valid && inst_ready;
  assign w_entry  = '{pc: r_resp_pc, inst: imem_rsp_data};
  assign w_target = align_pc(redirect_pc);

  assign inst_valid = !rst && !w_empty;
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out      <= '0;
      r_disc     <= '0;
    end else begin
      r_out <= r_out + CW'(w_req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        // Everything still in flight becomes stale: the old doomed responses
        // plus the live ones, less the one arriving now (dropped either way).
        // Using r_out directly keeps back-to-back redirects from counting the
        // same request twice.
        r_disc     <= r_out - CW'(imem_rsp_valid);
      end else begin
        if (w_req_fire)              r_fetch_pc <= r_fetch_pc + PC_INC;
        if (w_push)                  r_resp_pc  <= r_resp_pc + PC_INC;
        if (imem_rsp_valid && w_drop) r_disc    <= r_disc - CW'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_full && !w_pop));
  a_disc_le_out: assert property (@(posedge clk) disable iff (rst)
    r_disc <= r_out);

endmodule
